// File: rtl/vga_pkg.sv
// Shared constants, FSM encoding and edge arithmetic for the VGA object stages.
// Package only: no latency of its own.
// No flow control; everything here is combinational helpers and constants.
package vga_pkg;

  // Visible raster and the blank row on which frame-rate state is updated.
  localparam int unsigned H_PIX    = 640;
  localparam int unsigned V_PIX    = 480;
  localparam int unsigned REFR_ROW = V_PIX + 1;

  // Object defaults.
  localparam int unsigned BALL_SIZE_DEF = 8;
  localparam int unsigned BALL_V_DEF    = 2;

  // 3-bit colours {r,g,b}.
  localparam logic [2:0] RGB_BLACK = 3'b000;
  localparam logic [2:0] RGB_RED   = 3'b100;
  localparam logic [2:0] RGB_BLUE  = 3'b001;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAUSE = 2'd2
  } ball_state_e;

  // Result of advancing one axis by one frame.
  typedef struct packed {
    logic [9:0] pos;
    logic       fwd;   // 1 = increasing coordinate
    logic       flip;  // direction reversed this frame
  } axis_step_t;

  // Advance one axis. Sums are widened to 11 bits so pos+vel+size never wraps,
  // and the backward move checks pos < vel before subtracting.
  function automatic axis_step_t axis_step(input logic [9:0]  pos,
                                           input logic        fwd,
                                           input int unsigned vel,
                                           input int unsigned size,
                                           input int unsigned lim);
    axis_step_t r;
    logic [10:0] pos_w;
    logic [10:0] fwd_w;
    pos_w  = {1'b0, pos};
    fwd_w  = pos_w + 11'(vel);
    r.pos  = pos;
    r.fwd  = fwd;
    r.flip = 1'b0;
    if (fwd) begin
      if ((fwd_w + 11'(size - 1)) >= 11'(lim - 1)) begin
        r.pos  = 10'(lim - size);
        r.fwd  = 1'b0;
        r.flip = 1'b1;
      end else begin
        r.pos = fwd_w[9:0];
      end
    end else if (pos_w < 11'(vel)) begin
      r.pos  = '0;
      r.fwd  = 1'b1;
      r.flip = 1'b1;
    end else begin
      r.pos = pos - 10'(vel);
    end
    return r;
  endfunction

  // True when pix lies in [lo, lo+size-1], compared in 11 bits.
  function automatic logic in_span(input logic [9:0]  pix,
                                   input logic [9:0]  lo,
                                   input int unsigned size);
    logic [10:0] p;
    logic [10:0] l;
    p = {1'b0, pix};
    l = {1'b0, lo};
    return (p >= l) && (p <= (l + 11'(size - 1)));
  endfunction

endpackage

// File: rtl/vga_frame_tick.sv
// One-cycle pulse on the first clk of pixel (COL, ROW), i.e. once per frame in blank.
// Latency: combinational from pix_x_i/pix_y_i; edge detect register holds one cycle of history.
// No backpressure; the pulse is emitted unconditionally.
module vga_frame_tick
  import vga_pkg::*;
#(
  parameter int unsigned ROW = REFR_ROW,
  parameter int unsigned COL = 0
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [9:0] pix_x_i,
  input  logic [9:0] pix_y_i,
  output logic       refr_tick_o
);

  logic raw;
  logic raw_q;

  assign raw = (pix_y_i == 10'(ROW)) && (pix_x_i == 10'(COL));

  // Remember last cycle's match so a pixel lasting several clks fires once.
  always_ff @(posedge clk) begin
    if (reset) begin
      raw_q <= 1'b0;
    end else begin
      raw_q <= raw;
    end
  end

  assign refr_tick_o = raw & ~raw_q;

endmodule

// File: rtl/vga_ball_anim.sv
// Bouncing square ball: start/pause FSM, per-frame motion, bounce counter, RGB mux.
// Latency: rgb is registered, 1 clk after video_on/pix_x/pix_y.
// No backpressure; follows the raster from vga_sync every clk.
module vga_ball_anim
  import vga_pkg::*;
#(
  parameter int unsigned H_PIX     = vga_pkg::H_PIX,
  parameter int unsigned V_PIX     = vga_pkg::V_PIX,
  parameter int unsigned BALL_SIZE = BALL_SIZE_DEF,
  parameter int unsigned BALL_V    = BALL_V_DEF,
  parameter logic [2:0]  BALL_RGB  = RGB_RED,
  parameter logic [2:0]  BG_RGB    = RGB_BLUE
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       video_on,
  input  logic [9:0] pix_x,
  input  logic [9:0] pix_y,
  input  logic       start,
  input  logic       pause,
  output logic [2:0] rgb,
  output logic [7:0] bounce_cnt,
  output logic       running
);

  localparam logic [9:0] X_CTR = 10'((H_PIX - BALL_SIZE) / 2);
  localparam logic [9:0] Y_CTR = 10'((V_PIX - BALL_SIZE) / 2);

  logic        refr_tick;
  ball_state_e state_q, state_d;
  logic [9:0]  x_q, x_d, y_q, y_d;
  logic        dir_x_q, dir_x_d, dir_y_q, dir_y_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [2:0]  rgb_q, rgb_d;
  logic        move;
  logic        ball_on;
  axis_step_t  x_step, y_step;

  vga_frame_tick #(
    .ROW (V_PIX + 1),
    .COL (0)
  ) u_frame_tick (
    .clk         (clk),
    .reset       (reset),
    .pix_x_i     (pix_x),
    .pix_y_i     (pix_y),
    .refr_tick_o (refr_tick)
  );

  // FSM state register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state: start only matters from IDLE; pause toggles RUN/PAUSE as a level.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:  if (start)  state_d = ST_RUN;
      ST_RUN:   if (pause)  state_d = ST_PAUSE;
      ST_PAUSE: if (!pause) state_d = ST_RUN;
      default:  state_d = ST_IDLE;
    endcase
  end

  assign running = (state_q == ST_RUN);

  // Motion uses the registered state, so entering RUN on a tick edge does not move.
  assign move   = refr_tick && (state_q == ST_RUN);
  assign x_step = axis_step(x_q, dir_x_q, BALL_V, BALL_SIZE, H_PIX);
  assign y_step = axis_step(y_q, dir_y_q, BALL_V, BALL_SIZE, V_PIX);

  // Position, direction and bounce count next-state; IDLE pins the ball to centre.
  always_comb begin
    x_d     = x_q;
    y_d     = y_q;
    dir_x_d = dir_x_q;
    dir_y_d = dir_y_q;
    cnt_d   = cnt_q;
    if (state_q == ST_IDLE) begin
      x_d     = X_CTR;
      y_d     = Y_CTR;
      dir_x_d = 1'b1;
      dir_y_d = 1'b1;
    end else if (move) begin
      x_d     = x_step.pos;
      y_d     = y_step.pos;
      dir_x_d = x_step.fwd;
      dir_y_d = y_step.fwd;
      // A corner hit flips both axes but is one bounce.
      if (x_step.flip || y_step.flip) begin
        cnt_d = cnt_q + 8'd1;
      end
    end
  end

  // Motion registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      x_q     <= X_CTR;
      y_q     <= Y_CTR;
      dir_x_q <= 1'b1;
      dir_y_q <= 1'b1;
      cnt_q   <= '0;
    end else begin
      x_q     <= x_d;
      y_q     <= y_d;
      dir_x_q <= dir_x_d;
      dir_y_q <= dir_y_d;
      cnt_q   <= cnt_d;
    end
  end

  assign bounce_cnt = cnt_q;

  // Pixel colour; position only changes in vertical blank, so no tearing.
  always_comb begin
    ball_on = in_span(pix_x, x_q, BALL_SIZE) && in_span(pix_y, y_q, BALL_SIZE);
    rgb_d   = RGB_BLACK;
    if (video_on) begin
      rgb_d = ball_on ? BALL_RGB : BG_RGB;
    end
  end

  // Output pixel register.
  always_ff @(posedge clk) begin
    if (reset) begin
      rgb_q <= RGB_BLACK;
    end else begin
      rgb_q <= rgb_d;
    end
  end

  assign rgb = rgb_q;

endmodule

// File: tb/tb_vga_ball_anim.sv
// Bench for vga_ball_anim: two instances (640x480 step 2, and 480x480 step 37) share stimulus.
// A frame-level model predicts positions, bounce counts, running and the pixel colour.
// Compressed frames: the refresh pixel for 1 or 2 clks, then one probe pixel.
module tb_vga_ball_anim;

  logic       clk = 1'b0;
  logic       reset, start, pause, video_on;
  logic [9:0] pix_x, pix_y;
  logic [2:0] rgb_x [2];
  logic [7:0] cnt_x [2];
  logic       run_x [2];

  int n_checks = 0;
  int n_fail   = 0;

  // Model state, index 0 = dut_a, 1 = dut_b.
  int         ph [2];
  int         pv [2];
  int         pvel [2];
  int         m_x [2];
  int         m_y [2];
  int         m_cnt [2];
  bit         m_dx [2];
  bit         m_dy [2];
  bit         m_launched [2];
  bit         m_paused [2];
  bit         prev_raw;
  logic [2:0] exp_rgb [2];

  localparam int SZ = 8;

  always #5 clk = ~clk;

  vga_ball_anim dut_a (
    .clk(clk), .reset(reset), .video_on(video_on), .pix_x(pix_x), .pix_y(pix_y),
    .start(start), .pause(pause), .rgb(rgb_x[0]), .bounce_cnt(cnt_x[0]), .running(run_x[0])
  );

  vga_ball_anim #(.H_PIX(480), .V_PIX(480), .BALL_V(37)) dut_b (
    .clk(clk), .reset(reset), .video_on(video_on), .pix_x(pix_x), .pix_y(pix_y),
    .start(start), .pause(pause), .rgb(rgb_x[1]), .bounce_cnt(cnt_x[1]), .running(run_x[1])
  );

  function automatic void move_axis(input int pos, input bit fwd, input int lim, input int vel,
                                    output int npos, output bit nfwd, output bit flip);
    npos = pos; nfwd = fwd; flip = 1'b0;
    if (fwd) begin
      npos = pos + vel;
      if (npos + SZ - 1 >= lim - 1) begin npos = lim - SZ; nfwd = 1'b0; flip = 1'b1; end
    end else if (pos < vel) begin
      npos = 0; nfwd = 1'b1; flip = 1'b1;
    end else begin
      npos = pos - vel;
    end
  endfunction

  function automatic logic [2:0] pix_col(input int k, input bit von, input int px, input int py);
    if (!von) return 3'b000;
    if (px >= m_x[k] && px <= m_x[k] + SZ - 1 && py >= m_y[k] && py <= m_y[k] + SZ - 1)
      return 3'b100;
    return 3'b001;
  endfunction

  function automatic bit exp_run(input int k);
    return m_launched[k] && !m_paused[k];
  endfunction

  task automatic model_reset(input int k);
    m_x[k] = (ph[k] - SZ) / 2;
    m_y[k] = (pv[k] - SZ) / 2;
    m_dx[k] = 1'b1;
    m_dy[k] = 1'b1;
  endtask

  // One clock edge of the model: ball moves on a tick only if it was already running.
  task automatic model_step(input bit rst, input bit st, input bit ps, input bit tick);
    int nx, ny;
    bit ndx, ndy, fx, fy, was_launched;
    for (int k = 0; k < 2; k++) begin
      if (rst) begin
        model_reset(k);
        m_cnt[k] = 0;
        m_launched[k] = 1'b0;
        m_paused[k] = 1'b0;
      end else begin
        was_launched = m_launched[k];
        if (!was_launched) begin
          model_reset(k);
        end else if (tick && !m_paused[k]) begin
          move_axis(m_x[k], m_dx[k], ph[k], pvel[k], nx, ndx, fx);
          move_axis(m_y[k], m_dy[k], pv[k], pvel[k], ny, ndy, fy);
          m_x[k] = nx; m_dx[k] = ndx;
          m_y[k] = ny; m_dy[k] = ndy;
          if (fx || fy) m_cnt[k] = (m_cnt[k] + 1) % 256;
        end
        m_launched[k] = was_launched | st;
        m_paused[k] = was_launched ? ps : 1'b0;
      end
    end
  endtask

  task automatic do_cycle(input bit rst, input bit st, input bit ps, input bit von,
                          input int px, input int py);
    bit raw, tick;
    reset = rst; start = st; pause = ps; video_on = von;
    pix_x = 10'(px); pix_y = 10'(py);
    raw = (px == 0 && py == 481);
    tick = raw && !prev_raw;
    for (int k = 0; k < 2; k++) exp_rgb[k] = rst ? 3'b000 : pix_col(k, von, px, py);
    @(posedge clk);
    prev_raw = rst ? 1'b0 : raw;
    model_step(rst, st, ps, tick);
    #1;
  endtask

  // px < 0: random probe around one of the balls; py < 0: row inside dut_a's ball.
  task automatic frame(input bit dbl, input bit st, input bit ps, input bit von,
                       input int px, input int py);
    int k, qx, qy;
    do_cycle(1'b0, st, ps, 1'b0, 0, 481);
    if (dbl) do_cycle(1'b0, st, ps, 1'b0, 0, 481);
    qx = px; qy = py;
    if (px < 0) begin
      k = $urandom_range(0, 1);
      qx = m_x[k] + $urandom_range(0, 9) - 1;
      qy = m_y[k] + $urandom_range(0, 9) - 1;
      if (qx < 0) qx = 0;
      if (qy < 0) qy = 0;
    end else if (py < 0) begin
      qy = m_y[0] + 3;
    end
    do_cycle(1'b0, st, ps, von, qx, qy);
  endtask

  task automatic test_reset;
    int tx, ty;
    logic [2:0] want;
    for (int i = 0; i < 5; i++) begin
      do_cycle(1'b1, 1'b0, 1'b0, 1'b1, 320, 240);
      for (int k = 0; k < 2; k++) begin
        n_checks++;
        if (rgb_x[k] !== 3'b000 || cnt_x[k] !== 8'd0 || run_x[k] !== 1'b0) begin
          n_fail++;
          $display("FAIL reset_state dut%0d: rgb=%b cnt=%0d run=%b, want 000/0/0", k, rgb_x[k], cnt_x[k], run_x[k]);
        end
      end
    end
    do_cycle(1'b0, 1'b0, 1'b0, 1'b1, 320, 240);
    n_checks++;
    if (rgb_x[0] !== 3'b100) begin
      n_fail++; $display("FAIL reset_release_rgb: got %b want 100", rgb_x[0]);
    end
    n_checks++;
    if (rgb_x[1] !== exp_rgb[1]) begin
      n_fail++; $display("FAIL reset_release_rgb_b: got %b want %b", rgb_x[1], exp_rgb[1]);
    end
    // Ball edges at centre 316/236.
    for (int i = 0; i < 4; i++) begin
      case (i)
        0: begin tx = 316; ty = 236; want = 3'b100; end
        1: begin tx = 315; ty = 236; want = 3'b001; end
        2: begin tx = 323; ty = 243; want = 3'b100; end
        default: begin tx = 324; ty = 243; want = 3'b001; end
      endcase
      do_cycle(1'b0, 1'b0, 1'b0, 1'b1, tx, ty);
      n_checks++;
      if (rgb_x[0] !== want) begin
        n_fail++; $display("FAIL centre_probe (%0d,%0d): got %b want %b", tx, ty, rgb_x[0], want);
      end
    end
  endtask

  task automatic test_start;
    int tx, ty;
    logic [2:0] want;
    do_cycle(1'b0, 1'b1, 1'b0, 1'b1, 100, 100);
    for (int k = 0; k < 2; k++) begin
      n_checks++;
      if (run_x[k] !== 1'b1) begin
        n_fail++; $display("FAIL start_running dut%0d: got %b want 1", k, run_x[k]);
      end
    end
    // Raw held for two clks per frame: still exactly one move per frame.
    for (int f = 0; f < 3; f++) frame(1'b1, 1'b0, 1'b0, 1'b1, 0, 0);
    for (int i = 0; i < 4; i++) begin
      case (i)
        0: begin tx = 322; ty = 242; want = 3'b100; end
        1: begin tx = 321; ty = 242; want = 3'b001; end
        2: begin tx = 329; ty = 249; want = 3'b100; end
        default: begin tx = 330; ty = 249; want = 3'b001; end
      endcase
      do_cycle(1'b0, 1'b0, 1'b0, 1'b1, tx, ty);
      n_checks++;
      if (rgb_x[0] !== want) begin
        n_fail++; $display("FAIL three_frames_probe (%0d,%0d): got %b want %b", tx, ty, rgb_x[0], want);
      end
      n_checks++;
      if (rgb_x[1] !== exp_rgb[1]) begin
        n_fail++; $display("FAIL three_frames_probe_b: got %b want %b", rgb_x[1], exp_rgb[1]);
      end
    end
  endtask

  task automatic test_right_edge;
    int guard = 0;
    int cnt_before;
    while (!(m_x[0] == 630 && m_dx[0]) && guard < 400) begin
      frame(1'b0, 1'b0, 1'b0, 1'b1, -1, -1);
      guard++;
      for (int k = 0; k < 2; k++) begin
        n_checks++;
        if (rgb_x[k] !== exp_rgb[k] || cnt_x[k] !== 8'(m_cnt[k])) begin
          n_fail++;
          $display("FAIL approach_edge dut%0d: rgb=%b cnt=%0d want %b/%0d", k, rgb_x[k], cnt_x[k], exp_rgb[k], m_cnt[k]);
        end
      end
    end
    n_checks++;
    if (guard >= 400) begin
      n_fail++; $display("FAIL approach_edge_timeout: x=%0d never reached 630", m_x[0]);
    end
    cnt_before = m_cnt[0];
    frame(1'b0, 1'b0, 1'b0, 1'b1, 639, -1);
    n_checks++;
    if (rgb_x[0] !== 3'b100) begin
      n_fail++; $display("FAIL right_clamp_pix639: got %b want 100", rgb_x[0]);
    end
    n_checks++;
    if (cnt_x[0] !== 8'(cnt_before + 1)) begin
      n_fail++; $display("FAIL right_bounce_cnt: got %0d want %0d", cnt_x[0], cnt_before + 1);
    end
    frame(1'b0, 1'b0, 1'b0, 1'b1, 638, -1);
    n_checks++;
    if (rgb_x[0] !== 3'b001) begin
      n_fail++; $display("FAIL after_bounce_pix638: got %b want 001", rgb_x[0]);
    end
    do_cycle(1'b0, 1'b0, 1'b0, 1'b1, 630, m_y[0]);
    n_checks++;
    if (rgb_x[0] !== 3'b100) begin
      n_fail++; $display("FAIL after_bounce_pix630: got %b want 100", rgb_x[0]);
    end
  endtask

  task automatic test_pause;
    int sx, sy;
    do_cycle(1'b0, 1'b0, 1'b1, 1'b1, 5, 5);
    sx = m_x[0]; sy = m_y[0];
    for (int f = 0; f < 4; f++) begin
      frame(1'b0, f[0], 1'b1, 1'b1, sx + (f[0] ? SZ - 1 : 0), sy + (f[0] ? SZ - 1 : 0));
      n_checks++;
      if (rgb_x[0] !== 3'b100 || run_x[0] !== 1'b0) begin
        n_fail++; $display("FAIL paused_hold f%0d: rgb=%b run=%b want 100/0", f, rgb_x[0], run_x[0]);
      end
      n_checks++;
      if (rgb_x[1] !== exp_rgb[1] || run_x[1] !== 1'b0) begin
        n_fail++; $display("FAIL paused_hold_b f%0d: rgb=%b run=%b want %b/0", f, rgb_x[1], run_x[1], exp_rgb[1]);
      end
    end
    do_cycle(1'b0, 1'b0, 1'b0, 1'b1, 5, 5);
    n_checks++;
    if (run_x[0] !== 1'b1) begin
      n_fail++; $display("FAIL unpause_running: got %b want 1", run_x[0]);
    end
    frame(1'b0, 1'b0, 1'b0, 1'b1, sx, sy);
    n_checks++;
    if (rgb_x[0] !== exp_rgb[0] || rgb_x[0] === pix_col(0, 1'b1, sx - 1000, sy)) begin
      n_fail++; $display("FAIL unpause_moves: rgb at old origin %b want %b", rgb_x[0], exp_rgb[0]);
    end
  endtask

  task automatic test_random;
    bit ps = 1'b0;
    bit st;
    for (int f = 0; f < 3000; f++) begin
      if (ps) ps = ($urandom_range(0, 3) != 0);
      else    ps = ($urandom_range(0, 63) == 0);
      st = ($urandom_range(0, 15) == 0);
      frame($urandom_range(0, 7) == 0, st, ps, $urandom_range(0, 7) != 0, -1, -1);
      for (int k = 0; k < 2; k++) begin
        n_checks++;
        if (rgb_x[k] !== exp_rgb[k]) begin
          n_fail++; $display("FAIL rand_rgb dut%0d f%0d: got %b want %b", k, f, rgb_x[k], exp_rgb[k]);
        end
        n_checks++;
        if (cnt_x[k] !== 8'(m_cnt[k]) || run_x[k] !== exp_run(k)) begin
          n_fail++;
          $display("FAIL rand_cnt_run dut%0d f%0d: cnt=%0d run=%b want %0d/%b", k, f, cnt_x[k], run_x[k], m_cnt[k], exp_run(k));
        end
      end
    end
    do_cycle(1'b0, 1'b0, 1'b0, 1'b1, 5, 5);
  endtask

  task automatic test_wrap;
    int old_cnt;
    bit done = 1'b0;
    for (int f = 0; f < 8000 && !done; f++) begin
      old_cnt = m_cnt[1];
      frame(1'b0, 1'b0, 1'b0, 1'b1, -1, -1);
      for (int k = 0; k < 2; k++) begin
        n_checks++;
        if (rgb_x[k] !== exp_rgb[k] || cnt_x[k] !== 8'(m_cnt[k])) begin
          n_fail++;
          $display("FAIL wrap_run dut%0d f%0d: rgb=%b cnt=%0d want %b/%0d", k, f, rgb_x[k], cnt_x[k], exp_rgb[k], m_cnt[k]);
        end
      end
      if (old_cnt == 255 && m_cnt[1] == 0) begin
        done = 1'b1;
        n_checks++;
        if (cnt_x[1] !== 8'd0) begin
          n_fail++; $display("FAIL bounce_wrap: got %0d want 0", cnt_x[1]);
        end
      end
    end
    if (!done) begin
      n_checks++; n_fail++;
      $display("FAIL bounce_wrap_timeout: count %0d never wrapped", cnt_x[1]);
    end
  endtask

  task automatic test_video_off;
    do_cycle(1'b0, 1'b0, 1'b0, 1'b0, m_x[0] + 3, m_y[0] + 3);
    n_checks++;
    if (rgb_x[0] !== 3'b000) begin
      n_fail++; $display("FAIL video_off_in_ball: got %b want 000", rgb_x[0]);
    end
    do_cycle(1'b0, 1'b0, 1'b0, 1'b1, m_x[0] + 3, m_y[0] + 3);
    n_checks++;
    if (rgb_x[0] !== 3'b100) begin
      n_fail++; $display("FAIL video_on_in_ball: got %b want 100", rgb_x[0]);
    end
  endtask

  task automatic test_reset_in_pause;
    do_cycle(1'b0, 1'b0, 1'b1, 1'b1, 5, 5);
    n_checks++;
    if (run_x[0] !== 1'b0) begin
      n_fail++; $display("FAIL enter_pause: run=%b want 0", run_x[0]);
    end
    do_cycle(1'b1, 1'b0, 1'b1, 1'b1, 316, 236);
    for (int k = 0; k < 2; k++) begin
      n_checks++;
      if (cnt_x[k] !== 8'd0 || run_x[k] !== 1'b0 || rgb_x[k] !== 3'b000) begin
        n_fail++;
        $display("FAIL reset_in_pause dut%0d: cnt=%0d run=%b rgb=%b want 0/0/000", k, cnt_x[k], run_x[k], rgb_x[k]);
      end
    end
    do_cycle(1'b0, 1'b0, 1'b1, 1'b1, 316, 236);
    n_checks++;
    if (rgb_x[0] !== 3'b100 || run_x[0] !== 1'b0) begin
      n_fail++; $display("FAIL post_reset_centre: rgb=%b run=%b want 100/0", rgb_x[0], run_x[0]);
    end
    do_cycle(1'b0, 1'b0, 1'b0, 1'b1, 315, 236);
    n_checks++;
    if (rgb_x[0] !== 3'b001) begin
      n_fail++; $display("FAIL post_reset_left_of_ball: got %b want 001", rgb_x[0]);
    end
  endtask

  initial begin
    ph[0] = 640; pv[0] = 480; pvel[0] = 2;
    ph[1] = 480; pv[1] = 480; pvel[1] = 37;
    prev_raw = 1'b0;
    reset = 1'b1; start = 1'b0; pause = 1'b0; video_on = 1'b0;
    pix_x = '0; pix_y = '0;
    for (int k = 0; k < 2; k++) begin
      model_reset(k);
      m_cnt[k] = 0; m_launched[k] = 1'b0; m_paused[k] = 1'b0;
    end
    test_reset();
    test_start();
    test_right_edge();
    test_pause();
    test_random();
    test_wrap();
    test_video_off();
    test_reset_in_pause();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/vga_ball_anim.md
Name: vga_ball_anim

Overview:
- Pixel-generation stage directly downstream of vga_sync.
- Consumes the pixel coordinates and video_on from vga_sync, and produces registered 3-bit RGB for the VGA connector alongside vga_sync's hsync/vsync.
- Draws a square ball that bounces off the four screen edges.
- Ball motion is controlled by a start/pause FSM; a bounce counter is exposed for 7-segment display.

Parameters:
- H_PIX, 640, visible width in pixels.
- V_PIX, 480, visible height in pixels.
- BALL_SIZE, 8, ball side length in pixels.
- BALL_V, 2, pixels moved per axis per frame.
- BALL_RGB, 3'b100, ball colour.
- BG_RGB, 3'b001, background colour inside the visible area.

Ports:
- clk  input  1  system clock, same clock as vga_sync.
- reset  input  1  synchronous, active-high reset.
- video_on  input  1  visible-area flag from vga_sync.
- pix_x  input  10  current pixel column from vga_sync.
- pix_y  input  10  current pixel row from vga_sync.
- start  input  1  level; launches the ball from IDLE.
- pause  input  1  level; freezes the ball while RUN/PAUSE.
- rgb  output  3  registered pixel colour.
- bounce_cnt  output  8  number of bounce events, wraps modulo 256.
- running  output  1  high when the FSM is in RUN.

Behaviour:
- Clock and reset: one clock, clk. reset is synchronous and active-high. All state updates happen on the rising edge of clk.
- Reset values:
  - rgb=0, bounce_cnt=0, running=0.
  - FSM=IDLE.
  - ball_x=(H_PIX-BALL_SIZE)/2=316, ball_y=(V_PIX-BALL_SIZE)/2=236.
  - dir_x=+, dir_y=+.
- Frame tick:
  - raw = (pix_y==V_PIX+1 && pix_x==0). raw stays high for every clk cycle of that pixel (2 cycles at 50 MHz/25 MHz pixel rate).
  - raw is registered into raw_d. refr_tick = raw & ~raw_d, giving exactly one pulse per frame, during vertical blank.
- FSM states IDLE, RUN, PAUSE:
  - IDLE: position and direction are forced to the reset values every cycle. start=1 -> RUN at the next edge.
  - RUN: pause=1 -> PAUSE.
  - PAUSE: pause=0 -> RUN. start is ignored in RUN and PAUSE.
  - running = (state==RUN), registered with the state.
- Motion: occurs only when refr_tick=1 and the current registered state is RUN. If a transition into RUN happens on the same edge as refr_tick, there is no move that frame. Axes are updated independently:
  - x moving right: nx=x+BALL_V. If nx+BALL_SIZE-1 >= H_PIX-1, then nx=H_PIX-BALL_SIZE (632) and dir_x flips to left.
  - x moving left: if x < BALL_V, then nx=0 and dir_x flips to right; otherwise nx=x-BALL_V. No unsigned underflow is allowed.
  - y: same rules against V_PIX, with bottom clamp 472.
- Bounce count:
  - bounce_cnt increments by 1 on a tick where either or both axes flip. A corner hit counts as one.
  - It wraps 255 -> 0.
  - It is held in IDLE and PAUSE, and cleared only by reset.
- Pixel output, latency exactly 1 clk from video_on/pix_x/pix_y:
  - ball_on = ball_x <= pix_x <= ball_x+BALL_SIZE-1 and ball_y <= pix_y <= ball_y+BALL_SIZE-1.
  - rgb_next = !video_on ? 0 : ball_on ? BALL_RGB : BG_RGB.
  - ball_on uses the current position registers. Position only changes in vertical blank, so frames never tear.
- Reset mid-operation: on the reset edge everything returns to the reset values. The next rgb reflects the centered ball.
- Arithmetic: positions are 10-bit unsigned. Edge comparisons are computed in 11 bits to avoid overflow.

Decomposition:
- Shared package vga_pkg holds:
  - H_PIX, V_PIX, the refresh row (V_PIX+1);
  - the 3-bit colour constants;
  - the FSM state encoding: IDLE=2'd0, RUN=2'd1, PAUSE=2'd2.
- One natural sub-module: vga_frame_tick (raw compare plus edge detect -> refr_tick). It is reusable by later animated objects.
- Motion, FSM and pixel mux stay in vga_ball_anim.

Test Plan:
- Reset held for 5 clks with video_on=1, pix=(320,240) -> rgb=3'b100 one clk after release; bounce_cnt=0; running=0; position 316/236.
- start=1 for 1 clk, then drive 3 frames via vga_sync -> after 3 refr_ticks ball_x=322, ball_y=242. Exactly one move per frame even though raw lasts 2 clks.
- RUN with ball_x=630 moving right, one tick -> ball_x=632, dir_x=left, bounce_cnt+1. Next tick -> ball_x=630.
- Corner case: ball_x=1 moving left and ball_y=471 moving down, one tick -> x=0, y=472, both dirs flip, bounce_cnt increments by exactly 1.
- pause=1 across 4 ticks -> position unchanged and running=0. pause=0 -> running=1, next tick moves. Reset asserted in PAUSE -> IDLE, center position, bounce_cnt=0.
- video_on=0 with pix inside the ball -> rgb=0 next clk. bounce_cnt forced to 255 plus one bounce -> 0.
